hci_core_id_arbiter: RTL and testbench

//  Shares one HCI core target port among NI initiators using round-robin arbitration.

---
 rtl/hci_core_id_arbiter_pkg.sv | 16 +
 rtl/hci_core_id_arbiter_rr.sv | 38 +++
 rtl/hci_core_id_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_hci_core_id_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_core_id_arbiter_pkg.sv
// rtl/hci_core_id_arbiter_pkg.sv - shared types for the HCI core id arbiter
//
// Purpose: FSM state encoding and shared constants for hci_core_id_arbiter.
// Ports:   none (package).
package hci_core_id_arbiter_pkg;

    // ARB: free arbitration every cycle. LOCK: hold a stalled winner until granted.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } hci_id_arb_state_e;

    // Width of each per-initiator stall counter (optional perf feature).
    localparam int unsigned PERF_CW = 16;

endpackage

// File: rtl/hci_core_id_arbiter_rr.sv
// rtl/hci_core_id_arbiter_rr.sv - NI-bit round-robin picker
//
// Purpose: returns the first eligible index at or after rr_ptr_i, wrapping
//          from NI-1 back to 0.
// Ports:
//   elig_i    in   NI   eligible initiators
//   rr_ptr_i  in   IW   highest-priority index this cycle
//   winner_o  out  IW   selected index (0 when none)
//   valid_o   out  1    at least one initiator eligible
module hci_core_id_arbiter_rr #(
    parameter  int unsigned NI = 4,
    localparam int unsigned IW = $clog2(NI)
) (
    input  logic [NI-1:0] elig_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    int unsigned idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int unsigned j = 0; j < NI; j++) begin
            idx = int'(rr_ptr_i) + j;
            if (idx >= NI) begin
                idx = idx - NI;
            end
            if (!valid_o && elig_i[IW'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/hci_core_id_arbiter.sv
// rtl/hci_core_id_arbiter.sv - round-robin id-stamping arbiter for one HCI target port
//
// Purpose: shares one HCI core target port among NI initiators, stamps each
//          request with the initiator index, routes responses back by r_id and
//          bounds in-flight transactions per initiator to MAX_OUTST.
// Optional: HCI_ID_ARBITER_PERF_EN adds perf_stall_o (per-initiator 16-bit
//          saturating count of cycles requesting but not granted).
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync flush)
//   in_req_i/in_gnt_o, in_add_i/in_wen_i/in_data_i/in_be_i   initiator requests
//   in_r_valid_o/in_r_ready_i/in_r_data_o                   initiator responses
//   out_req_o/out_gnt_i, out_add_o/out_wen_o/out_data_o/out_be_o/out_id_o  target request
//   out_r_valid_i/out_r_id_i/out_r_data_i/out_r_ready_o     target response
//   error_o  sticky protocol error
//   perf_stall_o  [NI*16] stall counters (only with HCI_ID_ARBITER_PERF_EN)
module hci_core_id_arbiter
    import hci_core_id_arbiter_pkg::*;
#(
    parameter  int unsigned NI        = 4,
    parameter  int unsigned AW        = 32,
    parameter  int unsigned DW        = 32,
    parameter  int unsigned MAX_OUTST = 2,
    localparam int unsigned IW        = $clog2(NI),
    localparam int unsigned BW        = DW / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [NI-1:0]          in_req_i,
    output logic [NI-1:0]          in_gnt_o,
    input  logic [NI-1:0][AW-1:0]  in_add_i,
    input  logic [NI-1:0]          in_wen_i,
    input  logic [NI-1:0][DW-1:0]  in_data_i,
    input  logic [NI-1:0][BW-1:0]  in_be_i,
    output logic [NI-1:0]          in_r_valid_o,
    input  logic [NI-1:0]          in_r_ready_i,
    output logic [DW-1:0]          in_r_data_o,
    output logic                   out_req_o,
    input  logic                   out_gnt_i,
    output logic [AW-1:0]          out_add_o,
    output logic                   out_wen_o,
    output logic [DW-1:0]          out_data_o,
    output logic [BW-1:0]          out_be_o,
    output logic [IW-1:0]          out_id_o,
    input  logic                   out_r_valid_i,
    input  logic [IW-1:0]          out_r_id_i,
    input  logic [DW-1:0]          out_r_data_i,
    output logic                   out_r_ready_o,
    output logic                   error_o
`ifdef HCI_ID_ARBITER_PERF_EN
    ,
    output logic [NI*PERF_CW-1:0]  perf_stall_o
`endif
);

    localparam int unsigned      CW       = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(MAX_OUTST);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NI - 1);

    hci_id_arb_state_e        state_q, state_d;
    logic [IW-1:0]            lock_q, lock_d;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]            rr_winner;
    logic                     rr_valid;
    logic [IW-1:0]            sel;
    logic                     req_act;
    logic                     fire;
    logic                     lock_drop;
    logic [NI-1:0]            elig;
    logic [NI-1:0][CW-1:0]    cnt_q, cnt_d;
    logic                     error_q;
    logic                     rsp_hit, rsp_ready, rsp_cnt_zero, rsp_bad;

    // A full initiator is only masked from fresh arbitration; a locked
    // winner is never full because entering LOCK required eligibility.
    always_comb begin
        for (int unsigned i = 0; i < NI; i++) begin
            elig[i] = in_req_i[i] & (cnt_q[i] < CNT_MAX);
        end
    end

    hci_core_id_arbiter_rr #(
        .NI (NI)
    ) i_rr (
        .elig_i   (elig),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (rr_winner),
        .valid_o  (rr_valid)
    );

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        sel       = rr_winner;
        req_act   = rr_valid;
        lock_drop = 1'b0;
        case (state_q)
            ARB: begin
                if (rr_valid && !out_gnt_i) begin
                    state_d = LOCK;
                    lock_d  = rr_winner;
                end
            end
            LOCK: begin
                sel     = lock_q;
                // Once the locked initiator withdraws, stop presenting its request.
                req_act = in_req_i[lock_q];
                if (!in_req_i[lock_q]) begin
                    lock_drop = 1'b1;
                    state_d   = ARB;
                end else if (out_gnt_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign fire     = req_act & out_gnt_i;
    assign rr_ptr_d = fire ? ((sel == LAST_IDX) ? '0 : sel + 1'b1) : rr_ptr_q;

    always_comb begin
        for (int unsigned i = 0; i < NI; i++) begin
            in_gnt_o[i] = fire & (sel == IW'(i));
        end
    end

    // Fields are zeroed when idle so the target sees a quiet bus.
    assign out_req_o  = req_act;
    assign out_add_o  = req_act ? in_add_i[sel]  : '0;
    assign out_wen_o  = req_act ? in_wen_i[sel]  : 1'b0;
    assign out_data_o = req_act ? in_data_i[sel] : '0;
    assign out_be_o   = req_act ? in_be_i[sel]   : '0;
    assign out_id_o   = req_act ? sel            : '0;

    // Response decode: an out-of-range id or an id with nothing in flight
    // is swallowed (ready forced high) and flagged.
    always_comb begin
        rsp_hit      = 1'b0;
        rsp_ready    = 1'b0;
        rsp_cnt_zero = 1'b1;
        for (int unsigned k = 0; k < NI; k++) begin
            if (out_r_id_i == IW'(k)) begin
                rsp_hit      = 1'b1;
                rsp_ready    = in_r_ready_i[k];
                rsp_cnt_zero = (cnt_q[k] == '0);
            end
        end
        rsp_bad = out_r_valid_i & (~rsp_hit | rsp_cnt_zero);
    end

    assign out_r_ready_o = rsp_bad ? 1'b1 : rsp_ready;
    assign in_r_data_o   = out_r_data_i;

    always_comb begin
        for (int unsigned k = 0; k < NI; k++) begin
            in_r_valid_o[k] = out_r_valid_i & ~rsp_bad & (out_r_id_i == IW'(k));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NI; i++) begin
            cnt_d[i] = cnt_q[i];
            if (in_gnt_o[i] && !(in_r_valid_o[i] && in_r_ready_i[i])) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!in_gnt_o[i] && (in_r_valid_o[i] && in_r_ready_i[i])) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB;
            lock_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ARB;
            lock_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            if (rsp_bad || lock_drop) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;

`ifdef HCI_ID_ARBITER_PERF_EN
    logic [NI-1:0][PERF_CW-1:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (clear_i) begin
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NI; i++) begin
                if (in_req_i[i] && !in_gnt_o[i] && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + 1'b1;
                end
            end
        end
    end

    assign perf_stall_o = stall_q;
`else
    // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hci_core_id_arbiter.sv
// tb/tb_hci_core_id_arbiter.sv - directed self-checking bench for hci_core_id_arbiter
module tb_hci_core_id_arbiter;

    localparam int unsigned NI = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  clear_i;
    logic [NI-1:0]         in_req_i;
    logic [NI-1:0]         in_gnt_o;
    logic [NI-1:0][AW-1:0] in_add_i;
    logic [NI-1:0]         in_wen_i;
    logic [NI-1:0][DW-1:0] in_data_i;
    logic [NI-1:0][BW-1:0] in_be_i;
    logic [NI-1:0]         in_r_valid_o;
    logic [NI-1:0]         in_r_ready_i;
    logic [DW-1:0]         in_r_data_o;
    logic                  out_req_o;
    logic                  out_gnt_i;
    logic [AW-1:0]         out_add_o;
    logic                  out_wen_o;
    logic [DW-1:0]         out_data_o;
    logic [BW-1:0]         out_be_o;
    logic [IW-1:0]         out_id_o;
    logic                  out_r_valid_i;
    logic [IW-1:0]         out_r_id_i;
    logic [DW-1:0]         out_r_data_i;
    logic                  out_r_ready_o;
    logic                  error_o;
`ifdef HCI_ID_ARBITER_PERF_EN
    logic [NI*16-1:0]      perf_stall_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    hci_core_id_arbiter #(
        .NI (NI), .AW (AW), .DW (DW), .MAX_OUTST (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .in_req_i      (in_req_i),
        .in_gnt_o      (in_gnt_o),
        .in_add_i      (in_add_i),
        .in_wen_i      (in_wen_i),
        .in_data_i     (in_data_i),
        .in_be_i       (in_be_i),
        .in_r_valid_o  (in_r_valid_o),
        .in_r_ready_i  (in_r_ready_i),
        .in_r_data_o   (in_r_data_o),
        .out_req_o     (out_req_o),
        .out_gnt_i     (out_gnt_i),
        .out_add_o     (out_add_o),
        .out_wen_o     (out_wen_o),
        .out_data_o    (out_data_o),
        .out_be_o      (out_be_o),
        .out_id_o      (out_id_o),
        .out_r_valid_i (out_r_valid_i),
        .out_r_id_i    (out_r_id_i),
        .out_r_data_i  (out_r_data_i),
        .out_r_ready_o (out_r_ready_o),
        .error_o       (error_o)
`ifdef HCI_ID_ARBITER_PERF_EN
        ,
        .perf_stall_o  (perf_stall_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'hA000_0000 | 32'(i * 16);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        in_req_i      = '0;
        in_r_ready_i  = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        out_r_id_i    = '0;
        out_r_data_i  = 32'h5A5A_0001;
        for (int i = 0; i < NI; i++) begin
            in_add_i[i]  = addr_of(i);
            in_wen_i[i]  = i[0];
            in_data_i[i] = 32'hD000_0000 | 32'(i);
            in_be_i[i]   = BW'(i + 1);
        end

        // Reset state
        #12;
        check("rst_out_req", out_req_o, 0);
        check("rst_in_gnt", in_gnt_o, 0);
        check("rst_r_valid", in_r_valid_o, 0);
        check("rst_r_ready", out_r_ready_o, 0);
        check("rst_error", error_o, 0);
        check("rst_cnt", dut.cnt_q, 0);
        check("rst_state", dut.state_q, 0);
        check("rst_ptr", dut.rr_ptr_q, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        in_r_ready_i = 4'hF;
        tick();

        // 1. All requesting, granted every cycle, response one cycle later
        in_req_i  = 4'hF;
        out_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            out_r_valid_i = (c > 0);
            out_r_id_i    = IW'((c + 3) % 4);
            #2;
            check("t1_id", out_id_o, c % 4);
            check("t1_gnt", in_gnt_o, 1 << (c % 4));
            check("t1_add", out_add_o, addr_of(c % 4));
            check("t1_wen", out_wen_o, (c % 4) & 1);
            check("t1_rvalid", in_r_valid_o, (c > 0) ? (1 << ((c + 3) % 4)) : 0);
            check("t1_rdata", in_r_data_o, 32'h5A5A_0001);
            tick();
        end
        in_req_i      = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b1;
        out_r_id_i    = 2'd0;
        #2;
        check("t1_last_rvalid", in_r_valid_o, 4'b0001);
        check("t1_out_req_idle", out_req_o, 0);
        tick();
        out_r_valid_i = 1'b0;
        check("t1_cnt", dut.cnt_q, 0);
        check("t1_ptr", dut.rr_ptr_q, 1);
        check("t1_error", error_o, 0);

        // 2. Stalled winner stays locked while another initiator joins
        pulse_clear();
        in_req_i = 4'b0100;
        #2;
        check("t2_id_a", out_id_o, 2);
        check("t2_req_a", out_req_o, 1);
        check("t2_gnt_a", in_gnt_o, 0);
        tick();
        in_req_i = 4'b0110;
        #2;
        check("t2_state", dut.state_q, 1);
        check("t2_id_b", out_id_o, 2);
        tick();
        #2;
        check("t2_id_c", out_id_o, 2);
        check("t2_gnt_c", in_gnt_o, 0);
        tick();
        out_gnt_i = 1'b1;
        #2;
        check("t2_gnt_2", in_gnt_o, 4'b0100);
        tick();
        in_req_i = 4'b0010;
        #2;
        check("t2_gnt_1", in_gnt_o, 4'b0010);
        check("t2_id_1", out_id_o, 1);
        tick();
        in_req_i  = '0;
        out_gnt_i = 1'b0;
        out_r_valid_i = 1'b1;
        out_r_id_i    = 2'd2;
        #2;
        check("t2_rvalid_2", in_r_valid_o, 4'b0100);
        tick();
        out_r_id_i = 2'd1;
        tick();
        out_r_valid_i = 1'b0;
        check("t2_cnt", dut.cnt_q, 0);
        check("t2_error", error_o, 0);

        // 3. Full initiator masked until a response frees a slot
        pulse_clear();
        in_req_i  = 4'b0001;
        out_gnt_i = 1'b1;
        #2;
        check("t3_gnt_a", in_gnt_o, 4'b0001);
        tick();
        #2;
        check("t3_gnt_b", in_gnt_o, 4'b0001);
        tick();
        #2;
        check("t3_masked_req", out_req_o, 0);
        check("t3_masked_gnt", in_gnt_o, 0);
        check("t3_cnt_full", dut.cnt_q[0], 2);
        out_r_valid_i = 1'b1;
        out_r_id_i    = 2'd0;
        #1;
        check("t3_rvalid", in_r_valid_o, 4'b0001);
        tick();
        out_r_valid_i = 1'b0;
        #2;
        check("t3_cnt_after", dut.cnt_q[0], 1);
        check("t3_reelig", in_gnt_o, 4'b0001);
        tick();
        in_req_i  = '0;
        out_gnt_i = 1'b0;

        // 4. Grant and response to the same initiator in one cycle
        pulse_clear();
        in_req_i  = 4'b1000;
        out_gnt_i = 1'b1;
        tick();
        out_r_valid_i = 1'b1;
        out_r_id_i    = 2'd3;
        #2;
        check("t4_gnt", in_gnt_o, 4'b1000);
        check("t4_rvalid", in_r_valid_o, 4'b1000);
        tick();
        in_req_i      = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        #2;
        check("t4_cnt3", dut.cnt_q[3], 1);
        check("t4_error", error_o, 0);

        // 5. Response for an initiator with nothing in flight
        pulse_clear();
        in_r_ready_i  = 4'b0000;
        out_r_valid_i = 1'b1;
        out_r_id_i    = 2'd1;
        #2;
        check("t5_rvalid", in_r_valid_o, 0);
        check("t5_rready", out_r_ready_o, 1);
        check("t5_error_pre", error_o, 0);
        tick();
        out_r_valid_i = 1'b0;
        in_r_ready_i  = 4'hF;
        #2;
        check("t5_error_set", error_o, 1);
        pulse_clear();
        #2;
        check("t5_error_clr", error_o, 0);

        // Locked initiator withdrawing its request
        in_req_i = 4'b0100;
        tick();
        in_req_i = '0;
        tick();
        check("t7_state", dut.state_q, 0);
        check("t7_error", error_o, 1);
        pulse_clear();

        // 6. Asynchronous reset while locked with a full counter
        in_req_i  = 4'b0001;
        out_gnt_i = 1'b1;
        tick();
        tick();
        in_req_i  = 4'b0010;
        out_gnt_i = 1'b0;
        tick();
        #2;
        check("t6_state_lock", dut.state_q, 1);
        check("t6_cnt0", dut.cnt_q[0], 2);
        rst_ni       = 1'b0;
        in_req_i     = '0;
        in_r_ready_i = '0;
        #1;
        check("t6_out_req", out_req_o, 0);
        check("t6_gnt", in_gnt_o, 0);
        check("t6_out_id", out_id_o, 0);
        check("t6_out_add", out_add_o, 0);
        check("t6_rready", out_r_ready_o, 0);
        check("t6_error", error_o, 0);
        check("t6_cnt", dut.cnt_q, 0);
        check("t6_state", dut.state_q, 0);
        check("t6_ptr", dut.rr_ptr_q, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
